// File: rtl/fp_adder.sv
// rtl/fp_adder.sv - combinational IEEE-754 single-precision adder, truncating, flush-to-zero
module fp_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum,
    output logic        overflow,
    output logic        underflow
);

    logic              a_big;
    logic              s_l;
    logic              s_s;
    logic [7:0]        e_l;
    logic [7:0]        e_s;
    logic [7:0]        d;
    logic [23:0]       m_l;
    logic [23:0]       m_s;
    logic [25:0]       m_s_al;
    logic [26:0]       raw;
    logic [4:0]        lz;
    logic signed [9:0] exp_r;
    logic [22:0]       frac_r;
    logic              a_inf_nan;
    logic              b_inf_nan;
    logic              is_nan;

    // Align the smaller magnitude to the larger, add or subtract, normalise, then saturate
    always_comb begin
        a_big  = (a[30:0] >= b[30:0]);
        s_l    = a_big ? a[31] : b[31];
        s_s    = a_big ? b[31] : a[31];
        e_l    = a_big ? a[30:23] : b[30:23];
        e_s    = a_big ? b[30:23] : a[30:23];
        // Denormal inputs carry no hidden bit and are treated as zero
        m_l    = (e_l == 8'd0) ? 24'd0 : {1'b1, (a_big ? a[22:0] : b[22:0])};
        m_s    = (e_s == 8'd0) ? 24'd0 : {1'b1, (a_big ? b[22:0] : a[22:0])};
        d      = e_l - e_s;
        m_s_al = (d > 8'd25) ? 26'd0 : ({m_s, 2'b00} >> d);
        if (s_l == s_s) begin
            raw = {1'b0, m_l, 2'b00} + {1'b0, m_s_al};
        end else begin
            raw = {1'b0, m_l, 2'b00} - {1'b0, m_s_al};
        end

        lz = 5'd0;
        for (int i = 0; i < 26; i++) begin
            if (raw[i]) begin
                lz = 5'(25 - i);
            end
        end

        if (raw[26]) begin
            frac_r = raw[25:3];
            exp_r  = $signed({2'b00, e_l}) + 10'sd1;
        end else begin
            frac_r = 23'((raw[24:0] << lz) >> 2);
            exp_r  = $signed({2'b00, e_l}) - $signed({5'b00000, lz});
        end

        a_inf_nan = (a[30:23] == 8'hFF);
        b_inf_nan = (b[30:23] == 8'hFF);
        is_nan    = (a_inf_nan && (a[22:0] != 23'd0)) || (b_inf_nan && (b[22:0] != 23'd0)) ||
                    (a_inf_nan && b_inf_nan && (a[31] != b[31]));

        sum       = {s_l, exp_r[7:0], frac_r};
        overflow  = 1'b0;
        underflow = 1'b0;
        if (is_nan) begin
            sum = 32'h7FC0_0000;
        end else if (a_inf_nan) begin
            sum = a;
        end else if (b_inf_nan) begin
            sum = b;
        end else if (raw == 27'd0) begin
            sum = 32'd0;
        end else if (exp_r >= 10'sd255) begin
            sum      = {s_l, 8'hFF, 23'd0};
            overflow = 1'b1;
        end else if (exp_r <= 10'sd0) begin
            sum       = {s_l, 31'd0};
            underflow = 1'b1;
        end
    end

endmodule

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - round-robin arbiter sharing one fp_adder between two requesters
module fp_add_arbiter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    output logic             req1_ready,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_sum,
    output logic             rsp_id,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic [CNT_W-1:0] ops_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    logic        last_grant;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_id;
    logic        gnt0;
    logic        gnt1;
    logic [31:0] add_sum;
    logic        add_ovf;
    logic        add_unf;

    // On a tie the requester that did not win last time gets the grant
    assign gnt0       = req0_valid && (!req1_valid || last_grant);
    assign gnt1       = req1_valid && (!req0_valid || !last_grant);
    assign req0_ready = (state == IDLE) && gnt0;
    assign req1_ready = (state == IDLE) && gnt1;

    fp_adder u_fp_adder (
        .a         (op_a),
        .b         (op_b),
        .sum       (add_sum),
        .overflow  (add_ovf),
        .underflow (add_unf)
    );

    // Accept one pair, register the adder result a cycle later, hold it until consumed
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            last_grant    <= 1'b1;
            op_a          <= 32'd0;
            op_b          <= 32'd0;
            op_id         <= 1'b0;
            rsp_valid     <= 1'b0;
            rsp_sum       <= 32'd0;
            rsp_id        <= 1'b0;
            rsp_overflow  <= 1'b0;
            rsp_underflow <= 1'b0;
            ops_cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req0_ready) begin
                        op_a       <= req0_a;
                        op_b       <= req0_b;
                        op_id      <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= CALC;
                    end else if (req1_ready) begin
                        op_a       <= req1_a;
                        op_b       <= req1_b;
                        op_id      <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum       <= add_sum;
                    rsp_overflow  <= add_ovf;
                    rsp_underflow <= add_unf;
                    rsp_id        <= op_id;
                    rsp_valid     <= 1'b1;
                    state         <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        ops_cnt   <= ops_cnt + CNT_W'(1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - self-checking bench for fp_add_arbiter
module tb_fp_add_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req1_valid, rsp_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_overflow, rsp_underflow;
    logic [31:0] rsp_sum;
    logic [15:0] ops_cnt;
    logic        w_req0_ready, w_req1_ready, w_rsp_valid, w_rsp_id, w_rsp_overflow, w_rsp_underflow;
    logic [31:0] w_rsp_sum;
    logic [1:0]  w_ops_cnt;

    int          checks = 0;
    int          errors = 0;
    int          exp_cnt = 0;
    logic [34:0] sb[$];
    logic [34:0] exp_pkt;

    always #5 clk = ~clk;

    fp_add_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(rsp_sum), .rsp_id(rsp_id),
        .rsp_overflow(rsp_overflow), .rsp_underflow(rsp_underflow), .ops_cnt(ops_cnt)
    );

    fp_add_arbiter #(.CNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(w_req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(w_req1_ready),
        .rsp_valid(w_rsp_valid), .rsp_ready(rsp_ready), .rsp_sum(w_rsp_sum), .rsp_id(w_rsp_id),
        .rsp_overflow(w_rsp_overflow), .rsp_underflow(w_rsp_underflow), .ops_cnt(w_ops_cnt)
    );

    // Expected packet layout: {id, overflow, underflow, sum}; empty queue yields X so the compare fails
    function automatic logic [34:0] sb_pop();
        if (sb.size() == 0) return 'x;
        return sb.pop_front();
    endfunction

    task automatic test_reset();
        logic [53:0] snap;
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        req0_a = '0; req0_b = '0; req1_a = '0; req1_b = '0;
        repeat (2) @(negedge clk);
        snap = {rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_sum, ops_cnt, req0_ready, req1_ready};
        checks++;
        if (snap !== 54'd0) begin
            errors++; $display("FAIL reset_outputs: got %h expected 0", snap);
        end
        rst_n = 1'b1;
        exp_cnt = 0;
    endtask

    task automatic test_contention();
        int acc = 0;
        int rsp = 0;
        int last_acc = -1;
        int cyc = 0;
        logic exp_id;
        req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000;
        req1_a = 32'h4040_0000; req1_b = 32'hBF80_0000;
        req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
        while (rsp < 4 && cyc < 40) begin
            #1;
            checks++;
            if (req0_ready && req1_ready) begin
                errors++; $display("FAIL contention_both_ready: got 11 expected not both high");
            end
            if (rsp_valid) begin
                exp_pkt = sb_pop();
                checks++;
                if ({rsp_id, rsp_overflow, rsp_underflow, rsp_sum} !== exp_pkt) begin
                    errors++; $display("FAIL contention_rsp: got %h expected %h",
                        {rsp_id, rsp_overflow, rsp_underflow, rsp_sum}, exp_pkt);
                end
                rsp++;
            end
            if ((req0_valid && req0_ready) || (req1_valid && req1_ready)) begin
                exp_id = acc[0];
                checks++;
                if ({req1_ready, req0_ready} !== (exp_id ? 2'b10 : 2'b01)) begin
                    errors++; $display("FAIL contention_grant: got %b expected id %0d",
                        {req1_ready, req0_ready}, exp_id);
                end
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc != 3) begin
                        errors++; $display("FAIL contention_spacing: got %0d expected 3", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                sb.push_back(exp_id ? {1'b1, 2'b00, 32'h4000_0000} : {1'b0, 2'b00, 32'h4040_0000});
                acc++;
            end
            @(negedge clk);
            cyc++;
            if (acc == 4) begin
                req0_valid = 1'b0; req1_valid = 1'b0;
            end
        end
        exp_cnt += 4;
        checks++;
        if (rsp != 4 || ops_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL contention_done: got %0d rsp cnt %0d expected 4 rsp cnt %0d",
                rsp, ops_cnt, exp_cnt);
        end
    endtask

    task automatic test_single();
        req0_valid = 1'b1; req0_a = 32'h3F80_0000; req0_b = 32'h4000_0000; rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++; $display("FAIL single_ready: got %b expected 10", {req0_ready, req1_ready});
        end
        sb.push_back({1'b0, 2'b00, 32'h4040_0000});
        @(negedge clk);
        req0_valid = 1'b0; req0_a = 32'hDEAD_BEEF;
        #1;
        checks++;
        if ({rsp_valid, req0_ready, req1_ready} !== 3'b000) begin
            errors++; $display("FAIL single_calc: got %b expected 000", {rsp_valid, req0_ready, req1_ready});
        end
        @(negedge clk);
        exp_pkt = sb_pop();
        checks++;
        if ({rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_sum} !== {1'b1, exp_pkt}) begin
            errors++; $display("FAIL single_rsp: got %h expected %h",
                {rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_sum}, {1'b1, exp_pkt});
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if (rsp_valid !== 1'b0 || ops_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL single_done: got valid %b cnt %0d expected valid 0 cnt %0d",
                rsp_valid, ops_cnt, exp_cnt);
        end
    endtask

    task automatic test_wrap();
        checks++;
        if (w_ops_cnt !== 2'd1 || ops_cnt !== 16'd5) begin
            errors++; $display("FAIL wrap_cnt: got %0d/%0d expected 1/5", w_ops_cnt, ops_cnt);
        end
    endtask

    task automatic test_backpressure();
        req1_valid = 1'b1; req1_a = 32'h3FC0_0000; req1_b = 32'h4020_0000; rsp_ready = 1'b0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b01) begin
            errors++; $display("FAIL bp_ready: got %b expected 01", {req0_ready, req1_ready});
        end
        sb.push_back({1'b1, 2'b00, 32'h4080_0000});
        @(negedge clk);
        req1_valid = 1'b0; req0_valid = 1'b1;
        req0_a = $urandom(); req0_b = $urandom();
        @(negedge clk);
        exp_pkt = sb_pop();
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++;
            if ({rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_sum, req0_ready, req1_ready, ops_cnt} !==
                {1'b1, exp_pkt, 2'b00, 16'(exp_cnt)}) begin
                errors++; $display("FAIL bp_hold%0d: got %h expected %h", i,
                    {rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_sum, req0_ready, req1_ready, ops_cnt},
                    {1'b1, exp_pkt, 2'b00, 16'(exp_cnt)});
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b00) begin
            errors++; $display("FAIL bp_exit_ready: got %b expected 00", {req0_ready, req1_ready});
        end
        req0_valid = 1'b0;
        @(negedge clk);
        exp_cnt++;
        checks++;
        if (rsp_valid !== 1'b0 || ops_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL bp_release: got valid %b cnt %0d expected valid 0 cnt %0d",
                rsp_valid, ops_cnt, exp_cnt);
        end
    endtask

    task automatic test_flags();
        logic [31:0] ta[3] = '{32'h7F7F_FFFF, 32'h0080_0000, 32'h3F80_0000};
        logic [31:0] tb[3] = '{32'h7F7F_FFFF, 32'h80C0_0000, 32'hBF80_0000};
        logic [34:0] te[3] = '{{1'b0, 2'b10, 32'h7F80_0000},
                               {1'b0, 2'b01, 32'h8000_0000},
                               {1'b0, 2'b00, 32'h0000_0000}};
        for (int k = 0; k < 3; k++) begin
            req0_valid = 1'b1; req0_a = ta[k]; req0_b = tb[k];
            #1;
            checks++;
            if (req0_ready !== 1'b1) begin
                errors++; $display("FAIL flags_ready%0d: got %b expected 1", k, req0_ready);
            end
            sb.push_back(te[k]);
            @(negedge clk);
            req0_valid = 1'b0;
            @(negedge clk);
            exp_pkt = sb_pop();
            checks++;
            if ({rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_sum} !== {1'b1, exp_pkt}) begin
                errors++; $display("FAIL flags_rsp%0d: got %h expected %h", k,
                    {rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_sum}, {1'b1, exp_pkt});
            end
            @(negedge clk);
            exp_cnt++;
        end
        checks++;
        if (ops_cnt !== 16'(exp_cnt)) begin
            errors++; $display("FAIL flags_cnt: got %0d expected %0d", ops_cnt, exp_cnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [53:0] snap;
        req1_valid = 1'b1; req1_a = 32'h3F80_0000; req1_b = 32'h4000_0000; rsp_ready = 1'b1;
        @(negedge clk);
        req1_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        snap = {rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_sum, ops_cnt, req0_ready, req1_ready};
        checks++;
        if (snap !== 54'd0 || w_ops_cnt !== 2'd0 || w_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL resetmid_outputs: got %h/%0d expected 0", snap, w_ops_cnt);
        end
        sb.delete();
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        req0_valid = 1'b1; req0_a = 32'h3FC0_0000; req0_b = 32'h4020_0000;
        req1_valid = 1'b1; req1_a = 32'h4040_0000; req1_b = 32'hBF80_0000;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            errors++; $display("FAIL resetmid_first_grant: got %b expected 01", {req1_ready, req0_ready});
        end
        sb.push_back({1'b0, 2'b00, 32'h4080_0000});
        @(negedge clk);
        req0_valid = 1'b0; req1_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL resetmid_no_rsp: got %b expected 0", rsp_valid);
        end
        @(negedge clk);
        exp_pkt = sb_pop();
        checks++;
        if ({rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_sum} !== {1'b1, exp_pkt}) begin
            errors++; $display("FAIL resetmid_rsp: got %h expected %h",
                {rsp_valid, rsp_id, rsp_overflow, rsp_underflow, rsp_sum}, {1'b1, exp_pkt});
        end
        @(negedge clk);
        exp_cnt++;
        checks++;
        if (ops_cnt !== 16'(exp_cnt) || rsp_valid !== 1'b0) begin
            errors++; $display("FAIL resetmid_cnt: got %0d expected %0d", ops_cnt, exp_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_contention();
        test_single();
        test_wrap();
        test_backpressure();
        test_flags();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
